// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial initiator for a 4-bit ALU slice: captures one op/a/b transaction, walks it
// LSB nibble first through the slice with chained carry/compare, and hands back the full word.
module alu_nibble_sequencer #(
    parameter int NIBBLES   = 8,
    parameter bit SLT_FIXUP = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    output logic [3:0]             alu_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_cy_in,
    output logic                   alu_cmp_in,
    input  logic [3:0]             alu_res,
    input  logic                   alu_cy_out,
    input  logic                   alu_cmp_out,
    output logic [2:0]             nib_idx,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_d,
    output logic                   out_cmp
);
    localparam int         W    = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           cy;
    logic           cmp;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // nib_idx rests at 0 outside RUN, so the slice sees nibble 0 there.
    assign alu_a      = op_a[{nib_idx, 2'b00} +: 4];
    assign alu_b      = op_b[{nib_idx, 2'b00} +: 4];
    assign alu_cy_in  = (nib_idx == 3'd0) ? (alu_op[1] | alu_op[3]) : cy;
    assign alu_cmp_in = (nib_idx == 3'd0) ? 1'b1 : cmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            nib_idx <= '0;
            alu_op  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            cy      <= 1'b0;
            cmp     <= 1'b0;
            out_d   <= '0;
            out_cmp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_op  <= in_op;
                        op_a    <= in_a;
                        op_b    <= in_b;
                        nib_idx <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    out_d[{nib_idx, 2'b00} +: 4] <= alu_res;
                    cy  <= alu_cy_out;
                    cmp <= alu_cmp_out;
                    if (nib_idx == LAST) begin
                        out_cmp <= alu_cmp_out;
                        nib_idx <= '0;
                        state   <= DONE;
                        // Later assignment wins: the whole word is replaced, not just bit 0.
                        if (SLT_FIXUP && alu_op[2:1] == 2'b01)
                            out_d <= {{(W-1){1'b0}}, alu_cmp_out};
                    end else begin
                        nib_idx <= nib_idx + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural 4-bit add/sub slice plus a word-level result model.
module tb_alu_nibble_sequencer;
    localparam int NIBBLES = 8;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [3:0]   alu_op, alu_a, alu_b, alu_res;
    logic         alu_cy_in, alu_cmp_in, alu_cy_out, alu_cmp_out;
    logic [2:0]   nib_idx;
    logic         busy, out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_d;
    logic         out_cmp;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   cy_trace;

    alu_nibble_sequencer #(.NIBBLES(NIBBLES), .SLT_FIXUP(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cy_in(alu_cy_in), .alu_cmp_in(alu_cmp_in),
        .alu_res(alu_res), .alu_cy_out(alu_cy_out), .alu_cmp_out(alu_cmp_out),
        .nib_idx(nib_idx), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_cmp(out_cmp)
    );

    always #5 clk = ~clk;

    // External slice: ADD/SUB carry the zero flag along the compare chain; SLT/SLTU report less-than.
    logic [4:0] s_sum;
    logic [3:0] s_b;
    logic       s_ovf;
    always_comb begin
        s_b         = (alu_op[3] | alu_op[1]) ? ~alu_b : alu_b;
        s_sum       = {1'b0, alu_a} + {1'b0, s_b} + {4'b0, alu_cy_in};
        s_ovf       = (alu_a[3] == s_b[3]) && (s_sum[3] != alu_a[3]);
        alu_res     = s_sum[3:0];
        alu_cy_out  = s_sum[4];
        alu_cmp_out = alu_cmp_in & (s_sum[3:0] == 4'd0);
        if (alu_op[2:1] == 2'b01)
            alu_cmp_out = alu_op[0] ? ~s_sum[4] : (s_sum[3] ^ s_ovf);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic c);
        case (op)
            4'b1000: begin d = a - b; c = (d == 0); end
            4'b0010: begin c = ($signed(a) < $signed(b)); d = {31'b0, c}; end
            4'b0011: begin c = (a < b); d = {31'b0, c}; end
            default: begin d = a + b; c = (d == 0); end
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [4] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011};
        return ops[$urandom_range(0, 3)];
    endfunction

    // One transaction from IDLE to release; hold = cycles of back-pressure in DONE.
    task automatic run_txn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        logic [W-1:0] ed, held_d;
        logic         ec;
        int           lat;
        model(op, a, b, ed, ec);
        lat = 0;
        while (!in_ready && lat < 50) begin @(negedge clk); lat++; end
        chk("idle_ready", in_ready, 1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_op = rand_op(); in_a = $urandom; in_b = $urandom;
        chk("busy", busy, 1);
        chk("in_ready_run", in_ready, 0);
        lat = 0;
        cy_trace = '0;
        while (!out_valid && lat < 50) begin
            if (lat < NIBBLES) begin
                chk("nib_idx", nib_idx, lat);
                chk("alu_a", alu_a, a[4*lat +: 4]);
                cy_trace[lat] = alu_cy_in;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NIBBLES);
        chk("out_d", out_d, ed);
        chk("out_cmp", out_cmp, ec);
        held_d = out_d;
        repeat (hold) begin
            in_valid = 1'b1; in_op = rand_op(); in_a = $urandom; in_b = $urandom;
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_out_d", out_d, held_d);
            chk("bp_no_capture", alu_op, op);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, ed;
        logic [3:0]   rop;
        logic         ec;
        int           cyc, n_acc, n_res, prev_acc;
        bit           pend;
        logic [W-1:0] exp_q[$];

        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out_d", out_d, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(4'b0000, 32'h0000000F, 32'h00000001, 0);
        chk("add_cy_trace", cy_trace, 8'b00000010);
        run_txn(4'b1000, 32'd5, 32'd7, 0);
        chk("sub_cy_trace", cy_trace, 8'b00000001);
        run_txn(4'b0010, 32'hFFFFFFFF, 32'd1, 0);
        run_txn(4'b0011, 32'hFFFFFFFF, 32'd1, 0);
        run_txn(4'b0000, 32'hDEADBEEF, 32'h12345678, 5);

        // Reset in the middle of a RUN
        in_op = 4'b0000; in_a = 32'hFFFFFFFF; in_b = 32'h0000FFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (nib_idx != 3'd3 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("reach_nib3", nib_idx, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_nib", nib_idx, 0);
        chk("mid_rst_out_d", out_d, 0);
        chk("mid_rst_cmp", out_cmp, 0);
        chk("mid_rst_alu", {alu_op, alu_a, alu_b, alu_cy_in}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(4'b0000, 32'h12345678, 32'h11111111, 0);

        // Randomized single transactions with random back-pressure
        for (int i = 0; i < 20; i++)
            run_txn(rand_op(), $urandom, (i % 4 == 0) ? W'($urandom_range(0, 3)) : $urandom,
                    $urandom_range(0, 2));

        // Back-to-back: in_valid held, out_ready tied high
        out_ready = 1'b1;
        rop = rand_op(); ra = $urandom; rb = $urandom;
        in_op = rop; in_a = ra; in_b = rb; in_valid = 1'b1;
        cyc = 0; n_acc = 0; n_res = 0; prev_acc = -1; pend = 0;
        while (n_res < 4 && cyc < 200) begin
            if (in_ready && in_valid) begin
                model(rop, ra, rb, ed, ec);
                exp_q.push_back(ed);
                if (prev_acc >= 0) chk("b2b_spacing", cyc - prev_acc, NIBBLES + 2);
                prev_acc = cyc;
                n_acc++;
                pend = 1;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 0;
                if (n_acc >= 4) in_valid = 1'b0;
                rop = rand_op(); ra = $urandom; rb = $urandom;
                in_op = rop; in_a = ra; in_b = rb;
            end
            if (out_valid) begin
                chk("b2b_out_d", out_d, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
                n_res++;
            end
        end
        chk("b2b_results", n_res, 4);
        out_ready = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
